net_rx_packet: RTL and testbench

Store-and-forward packet deframer directly downstream of the multi-phase line receiver. Consumes its stream of 64-bit words, each flagged as data or end-of-packet; buffers data words and validates the end word's length and CRC-32 against the buffered words. Emits only complete, valid packets on a ready/valid stream with a last marker, and counts discarded packets per cause.

---
 rtl/net_rx_packet.sv | 186 ++++++++++++++++++
 tb/tb_net_rx_packet.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_rx_packet.sv
// Store-and-forward packet deframer: buffers data words, validates the end word's
// length and CRC-32, and forwards only committed packets on a ready/valid stream.
module net_rx_packet #(
  parameter int BITS      = 64,
  parameter int DEPTH     = 512,
  parameter int MAX_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] in_data,
  input  logic            in_end,
  input  logic            in_valid,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     cnt_good,
  output logic [15:0]     cnt_crc_err,
  output logic [15:0]     cnt_len_err,
  output logic [15:0]     cnt_overflow
);
  // state | meaning
  // RECV  | accepting data words of the current packet
  // DROP  | packet abandoned (buffer full or too long), waiting for its end word

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [15:0]   MAX_P    = 16'(MAX_WORDS);
  localparam logic [31:0]   CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic {RECV = 1'b0, DROP = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [BITS:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, cm_ptr, rd_ptr, used, wr_last;
  logic [31:0]     crc;
  logic [15:0]     count;
  logic            drop_ovf;
  logic [BITS-1:0] last_data;

  logic            data_in, end_in, full;
  logic            accept, go_ovf, go_len;
  logic [15:0]     n_field;
  logic            len_bad, crc_bad;
  logic            v_good, v_crc, v_len, v_ovf;

  logic [BITS:0]   ram_q, skid_q;
  logic            ram_v, skid_v, pop, issue;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [BITS-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < BITS; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign data_in = in_valid && !in_end;
  assign end_in  = in_valid && in_end;
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == DEPTH_P);
  assign wr_last = wr_ptr - ONE;
  assign n_field = in_data[BITS-1 -: 16];
  assign len_bad = (n_field != count) || (n_field == 16'd0);
  assign crc_bad = (~crc) != in_data[31:0];

  always_ff @(posedge clk) begin
    if (rst) state <= RECV;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    go_ovf    = 1'b0;
    go_len    = 1'b0;
    v_good    = 1'b0;
    v_crc     = 1'b0;
    v_len     = 1'b0;
    v_ovf     = 1'b0;
    case (state)
      RECV: begin
        if (data_in) begin
          if (full) begin
            state_nxt = DROP;
            go_ovf    = 1'b1;
          end else if (count == MAX_P) begin
            state_nxt = DROP;
            go_len    = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
        if (end_in) begin
          if (len_bad)      v_len  = 1'b1;
          else if (crc_bad) v_crc  = 1'b1;
          else              v_good = 1'b1;
        end
      end
      DROP: begin
        if (end_in) begin
          state_nxt = RECV;
          if (drop_ovf) v_ovf = 1'b1;
          else          v_len = 1'b1;
        end
      end
      default: state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      cm_ptr       <= '0;
      count        <= '0;
      crc          <= CRC_INIT;
      drop_ovf     <= 1'b0;
      last_data    <= '0;
      cnt_good     <= '0;
      cnt_crc_err  <= '0;
      cnt_len_err  <= '0;
      cnt_overflow <= '0;
    end else begin
      if (accept) begin
        wr_ptr    <= wr_ptr + ONE;
        count     <= count + 16'd1;
        crc       <= crc_step(crc, in_data);
        last_data <= in_data;
      end
      if (go_ovf) drop_ovf <= 1'b1;
      if (go_len) drop_ovf <= 1'b0;
      if (end_in) begin
        count <= '0;
        crc   <= CRC_INIT;
        if (v_good) cm_ptr <= wr_ptr;
        else        wr_ptr <= cm_ptr;
      end
      if (v_good && cnt_good     != 16'hFFFF) cnt_good     <= cnt_good + 16'd1;
      if (v_crc  && cnt_crc_err  != 16'hFFFF) cnt_crc_err  <= cnt_crc_err + 16'd1;
      if (v_len  && cnt_len_err  != 16'hFFFF) cnt_len_err  <= cnt_len_err + 16'd1;
      if (v_ovf  && cnt_overflow != 16'hFFFF) cnt_overflow <= cnt_overflow + 16'd1;
    end
  end

  // The commit rewrites the packet's final word with its last flag set; an end
  // word never coincides with a data word, so one write port suffices.
  always_ff @(posedge clk) begin
    if (accept)      mem[wr_ptr[AW-1:0]]  <= {1'b0, in_data};
    else if (v_good) mem[wr_last[AW-1:0]] <= {1'b1, last_data};
  end

  // ram_q is the registered read; skid_q holds the older word when the consumer
  // stalls, so the read enable never depends on out_ready.
  assign pop       = out_valid && out_ready;
  assign issue     = (rd_ptr != cm_ptr) && !skid_v;
  assign out_valid = ram_v || skid_v;
  assign out_data  = skid_v ? skid_q[BITS-1:0] : ram_q[BITS-1:0];
  assign out_last  = skid_v ? skid_q[BITS]     : ram_q[BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      ram_q  <= '0;
      ram_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
    end else if (issue) begin
      ram_q  <= mem[rd_ptr[AW-1:0]];
      ram_v  <= 1'b1;
      rd_ptr <= rd_ptr + ONE;
      if (ram_v && !pop) begin
        skid_q <= ram_q;
        skid_v <= 1'b1;
      end
    end else if (skid_v) begin
      if (pop) skid_v <= 1'b0;
    end else if (pop) begin
      ram_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_net_rx_packet.sv
// Directed bench for net_rx_packet: a full-size instance and a DEPTH=16 instance
// for the overflow and pointer-wrap scenarios.
module tb_net_rx_packet;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] in_data, out_data;
  logic        in_end, in_valid, out_last, out_valid, out_ready;
  logic [15:0] cnt_good, cnt_crc_err, cnt_len_err, cnt_overflow;

  logic [63:0] s_in_data, s_out_data;
  logic        s_in_end, s_in_valid, s_out_last, s_out_valid, s_out_ready;
  logic [15:0] s_cnt_good, s_cnt_crc_err, s_cnt_len_err, s_cnt_overflow;

  net_rx_packet dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_end(in_end), .in_valid(in_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_good(cnt_good), .cnt_crc_err(cnt_crc_err), .cnt_len_err(cnt_len_err),
    .cnt_overflow(cnt_overflow)
  );

  net_rx_packet #(.BITS(64), .DEPTH(16), .MAX_WORDS(16)) dut_s (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_end(s_in_end), .in_valid(s_in_valid),
    .out_data(s_out_data), .out_last(s_out_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .cnt_good(s_cnt_good), .cnt_crc_err(s_cnt_crc_err),
    .cnt_len_err(s_cnt_len_err), .cnt_overflow(s_cnt_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] rx_q[$];
  logic [64:0] rxs_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready)     rx_q.push_back({out_last, out_data});
      if (s_out_valid && s_out_ready) rxs_q.push_back({s_out_last, s_out_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Byte-serial CRC-32 over the little-endian bytes of each word.
  function automatic logic [31:0] crc_model(input logic [63:0] w[$]);
    logic [31:0] c;
    logic [7:0]  by;
    c = 32'hFFFF_FFFF;
    foreach (w[i]) begin
      for (int b = 0; b < 8; b++) begin
        by = w[i][8*b +: 8];
        c  = c ^ {24'd0, by};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic drive(input bit sel, input logic [63:0] d, input logic e);
    if (sel) begin s_in_data = d; s_in_end = e; s_in_valid = 1'b1; end
    else     begin in_data = d;   in_end = e;   in_valid = 1'b1;   end
    @(posedge clk); #1;
    in_valid = 1'b0; in_end = 1'b0; s_in_valid = 1'b0; s_in_end = 1'b0;
  endtask

  task automatic send_pkt(input bit sel, input logic [63:0] w[$], input logic [15:0] n,
                          input logic [31:0] crc_flip);
    foreach (w[i]) drive(sel, w[i], 1'b0);
    drive(sel, {n, 16'h0000, crc_model(w) ^ crc_flip}, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_end = 1'b0; in_data = '0;
    s_in_valid = 1'b0; s_in_end = 1'b0; s_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    rxs_q.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b0; s_out_ready = 1'b0;
    do_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 64'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
    n_checks++; if ({cnt_good, cnt_crc_err, cnt_len_err, cnt_overflow} !== 64'd0)
      $display("FAIL reset_counters: got %h want 0", {cnt_good, cnt_crc_err, cnt_len_err, cnt_overflow}); else n_pass++;
    n_checks++; if (s_out_valid !== 1'b0) $display("FAIL reset_small_out_valid: got %b want 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    in_data = 64'h0001_0000_6522_DF69; in_end = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_end = 1'b0;
    n_checks++; if (cnt_good !== 16'd1) $display("FAIL single_cnt_good_t1: got %0d want 1", cnt_good); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_t1: got %b want 0", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid_t2: got %b want 1", out_valid); else n_pass++;
    n_checks++; if ({out_last, out_data} !== {1'b1, 64'd0})
      $display("FAIL single_word_t2: got %h want %h", {out_last, out_data}, {1'b1, 64'd0}); else n_pass++;
    idle(5);
    n_checks++; if (rx_q.size() !== 1) $display("FAIL single_count: got %0d want 1", rx_q.size()); else n_pass++;
  endtask

  task automatic test_crc_err();
    logic [63:0] w[$];
    do_reset();
    out_ready = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    drive(1'b0, 64'h0001_0000_6522_DF68, 1'b1);
    idle(5);
    n_checks++; if (cnt_crc_err !== 16'd1) $display("FAIL crc_cnt: got %0d want 1", cnt_crc_err); else n_pass++;
    n_checks++; if (rx_q.size() !== 0) $display("FAIL crc_nothing_out: got %0d want 0", rx_q.size()); else n_pass++;
    n_checks++; if ({dut.wr_ptr, dut.cm_ptr} !== 20'd0)
      $display("FAIL crc_rollback: got wr=%0d cm=%0d want 0/0", dut.wr_ptr, dut.cm_ptr); else n_pass++;
    w = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0001};
    send_pkt(1'b0, w, 16'd3, 32'd0);
    idle(8);
    n_checks++; if (rx_q.size() !== 3) $display("FAIL crc_follow_count: got %0d want 3", rx_q.size()); else n_pass++;
    if (rx_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (rx_q[i] !== {(i == 2), w[i]})
          $display("FAIL crc_follow_word%0d: got %h want %h", i, rx_q[i], {(i == 2), w[i]}); else n_pass++;
      end
    end
    n_checks++; if (cnt_good !== 16'd1) $display("FAIL crc_follow_good: got %0d want 1", cnt_good); else n_pass++;
  endtask

  task automatic test_len_err();
    logic [63:0] w[$];
    do_reset();
    out_ready = 1'b1;
    w = {64'h0000_0000_0000_00AA};
    send_pkt(1'b0, w, 16'd2, 32'd0);
    w.delete();
    for (int i = 0; i < 257; i++) w.push_back(64'(i) * 64'h0101_0101_0101_0101 + 64'd7);
    send_pkt(1'b0, w, 16'd257, 32'd0);
    idle(5);
    n_checks++; if (cnt_len_err !== 16'd2) $display("FAIL len_cnt: got %0d want 2", cnt_len_err); else n_pass++;
    n_checks++; if (rx_q.size() !== 0) $display("FAIL len_nothing_out: got %0d want 0", rx_q.size()); else n_pass++;
    n_checks++; if ({cnt_good, cnt_crc_err, cnt_overflow} !== 48'd0)
      $display("FAIL len_other_counters: got %h want 0", {cnt_good, cnt_crc_err, cnt_overflow}); else n_pass++;
    void'(w.pop_back());
    send_pkt(1'b0, w, 16'd256, 32'd0);
    idle(270);
    n_checks++; if (rx_q.size() !== 256) $display("FAIL len_max_count: got %0d want 256", rx_q.size()); else n_pass++;
    if (rx_q.size() == 256) begin
      n_checks++; if (rx_q[255] !== {1'b1, w[255]})
        $display("FAIL len_max_last: got %h want %h", rx_q[255], {1'b1, w[255]}); else n_pass++;
      n_checks++; if (rx_q[254] !== {1'b0, w[254]})
        $display("FAIL len_max_penult: got %h want %h", rx_q[254], {1'b0, w[254]}); else n_pass++;
    end
    n_checks++; if (cnt_good !== 16'd1) $display("FAIL len_max_good: got %0d want 1", cnt_good); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] w1[$], w2[$], w3[$];
    do_reset();
    s_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w1.push_back(64'd100 + 64'(i));
      w2.push_back(64'd200 + 64'(i));
      w3.push_back(64'd300 + 64'(i));
    end
    send_pkt(1'b1, w1, 16'd10, 32'd0);
    idle(5);
    send_pkt(1'b1, w2, 16'd10, 32'd0);
    idle(5);
    n_checks++; if (s_cnt_overflow !== 16'd1) $display("FAIL ovf_cnt: got %0d want 1", s_cnt_overflow); else n_pass++;
    n_checks++; if (s_cnt_good !== 16'd1) $display("FAIL ovf_good: got %0d want 1", s_cnt_good); else n_pass++;
    n_checks++; if ({s_out_valid, s_out_data} !== {1'b1, 64'd100})
      $display("FAIL ovf_head_held: got %h want %h", {s_out_valid, s_out_data}, {1'b1, 64'd100}); else n_pass++;
    s_out_ready = 1'b1;
    idle(20);
    n_checks++; if (rxs_q.size() !== 10) $display("FAIL ovf_out_count: got %0d want 10", rxs_q.size()); else n_pass++;
    if (rxs_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        n_checks++; if (rxs_q[i] !== {(i == 9), w1[i]})
          $display("FAIL ovf_word%0d: got %h want %h", i, rxs_q[i], {(i == 9), w1[i]}); else n_pass++;
      end
    end
    send_pkt(1'b1, w3, 16'd10, 32'd0);
    idle(15);
    n_checks++; if (rxs_q.size() !== 20) $display("FAIL wrap_count: got %0d want 20", rxs_q.size()); else n_pass++;
    if (rxs_q.size() == 20) begin
      n_checks++; if (rxs_q[19] !== {1'b1, w3[9]})
        $display("FAIL wrap_last: got %h want %h", rxs_q[19], {1'b1, w3[9]}); else n_pass++;
      n_checks++; if (rxs_q[15] !== {1'b0, w3[5]})
        $display("FAIL wrap_mid: got %h want %h", rxs_q[15], {1'b0, w3[5]}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] words[$];
    logic [64:0] exp_q[$];
    int          lens[4];
    int          base;
    lens = '{1, 3, 5, 2};
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < lens[p]; i++) begin
        words.push_back({$urandom, $urandom});
        exp_q.push_back({(i == lens[p] - 1), words[words.size() - 1]});
      end
    fork
      begin
        logic [63:0] pw[$];
        base = 0;
        for (int p = 0; p < 4; p++) begin
          pw.delete();
          for (int i = 0; i < lens[p]; i++) pw.push_back(words[base + i]);
          base += lens[p];
          send_pkt(1'b0, pw, 16'(lens[p]), 32'd0);
        end
      end
      begin
        logic        stalled;
        logic [64:0] held;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 80; c++) begin
          @(posedge clk); #1;
          if (stalled) begin
            n_checks++; if ({out_valid, out_last, out_data} !== {1'b1, held})
              $display("FAIL b2b_stall_stable: got %h want %h", {out_valid, out_last, out_data}, {1'b1, held});
            else n_pass++;
          end
          out_ready = 1'($urandom_range(0, 1));
          stalled   = out_valid && !out_ready;
          held      = {out_last, out_data};
        end
      end
    join
    out_ready = 1'b1;
    idle(20);
    n_checks++; if (rx_q.size() !== exp_q.size())
      $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    if (rx_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        n_checks++; if (rx_q[i] !== exp_q[i])
          $display("FAIL b2b_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
      end
    end
    n_checks++; if (cnt_good !== 16'd4) $display("FAIL b2b_good: got %0d want 4", cnt_good); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] w[$];
    do_reset();
    out_ready = 1'b0;
    w = {64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0003};
    send_pkt(1'b0, w, 16'd3, 32'd0);
    drive(1'b0, 64'hBBBB_0000_0000_0001, 1'b0);
    drive(1'b0, 64'hBBBB_0000_0000_0002, 1'b0);
    n_checks++; if ({out_valid, cnt_good} !== {1'b1, 16'd1})
      $display("FAIL rstmid_pre: got %h want %h", {out_valid, cnt_good}, {1'b1, 16'd1}); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({out_valid, out_last, out_data} !== 66'd0)
      $display("FAIL rstmid_outputs: got %h want 0", {out_valid, out_last, out_data}); else n_pass++;
    n_checks++; if ({cnt_good, cnt_crc_err, cnt_len_err, cnt_overflow} !== 64'd0)
      $display("FAIL rstmid_counters: got %h want 0", {cnt_good, cnt_crc_err, cnt_len_err, cnt_overflow}); else n_pass++;
    rx_q.delete();
    out_ready = 1'b1;
    w = {64'hCCCC_0000_0000_0001, 64'hCCCC_0000_0000_0002};
    send_pkt(1'b0, w, 16'd2, 32'd0);
    idle(10);
    n_checks++; if (rx_q.size() !== 2) $display("FAIL rstmid_count: got %0d want 2", rx_q.size()); else n_pass++;
    if (rx_q.size() == 2) begin
      n_checks++; if (rx_q[0] !== {1'b0, w[0]}) $display("FAIL rstmid_word0: got %h want %h", rx_q[0], {1'b0, w[0]}); else n_pass++;
      n_checks++; if (rx_q[1] !== {1'b1, w[1]}) $display("FAIL rstmid_word1: got %h want %h", rx_q[1], {1'b1, w[1]}); else n_pass++;
    end
    n_checks++; if (cnt_good !== 16'd1) $display("FAIL rstmid_good: got %0d want 1", cnt_good); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_end = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s_in_data = '0; s_in_end = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    test_reset();
    test_single();
    test_crc_err();
    test_len_err();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
